// File: rtl/led_bank_ctrl.sv
// Parametrised LED bank driver: per-channel off/on/blink/PWM modes behind a register write port.
// Optional LED_BANK_BREATHE_EN adds a shared triangle-wave duty source for mode 11 channels with duty 0.

module led_bank_lane #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic [PWM_BITS+1:0] wr_data,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                blink_phase,
  input  logic [PWM_BITS-1:0] breathe_duty,
  output logic [PWM_BITS+1:0] cfg,
  output logic                led
);
  logic [1:0]          mode;
  logic [PWM_BITS-1:0] duty, duty_eff;
  logic                led_nxt;

  assign mode = cfg[PWM_BITS+1:PWM_BITS];
  assign duty = cfg[PWM_BITS-1:0];
  // breathe_duty is tied to zero when the generator is absent, so duty 0 stays off
  assign duty_eff = (duty == '0) ? breathe_duty : duty;

  always_comb begin
    led_nxt = 1'b0;
    case (mode)
      2'b00: led_nxt = 1'b0;
      2'b01: led_nxt = 1'b1;
      2'b10: led_nxt = blink_phase;
      2'b11: led_nxt = (pwm_cnt < duty_eff);
      default: led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg <= {2'b01, {PWM_BITS{1'b0}}};
      led <= 1'b0;
    end else begin
      if (wr) cfg <= wr_data;
      led <= led_nxt;
    end
  end
endmodule

module led_bank_ctrl #(
  parameter int NLEDS         = 5,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE      = 4,
  parameter int BLINK_PERIODS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [3:0]          wr_addr,
  input  logic [PWM_BITS+1:0] wr_data,
  output logic [PWM_BITS+1:0] rd_data,
  output logic [NLEDS-1:0]    led,
  output logic                period_tick
);
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW  = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

  logic [PSW-1:0]                  prescaler;
  logic [PWM_BITS-1:0]             pwm_cnt;
  logic [BW-1:0]                   blink_cnt;
  logic                            blink_phase;
  logic [PWM_BITS-1:0]             breathe_duty;
  logic [NLEDS-1:0][PWM_BITS+1:0]  cfg;
  logic                            step, wrap;

  assign step = (prescaler == PSW'(PRESCALE - 1));
  assign wrap = step && (pwm_cnt == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler   <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      prescaler   <= step ? '0 : prescaler + 1'b1;
      if (step) pwm_cnt <= pwm_cnt + 1'b1;
      period_tick <= wrap;
      if (wrap) begin
        if (blink_cnt == BW'(BLINK_PERIODS - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

`ifdef LED_BANK_BREATHE_EN
  logic breathe_up;

  // Triangle 0..max..0: direction flips on the step that lands on an end value
  always_ff @(posedge clk) begin
    if (rst) begin
      breathe_duty <= '0;
      breathe_up   <= 1'b1;
    end else if (period_tick) begin
      if (breathe_up) begin
        breathe_duty <= breathe_duty + 1'b1;
        if (breathe_duty == {{(PWM_BITS-1){1'b1}}, 1'b0}) breathe_up <= 1'b0;
      end else begin
        breathe_duty <= breathe_duty - 1'b1;
        if (breathe_duty == {{(PWM_BITS-1){1'b0}}, 1'b1}) breathe_up <= 1'b1;
      end
    end
  end
`else
  assign breathe_duty = '0;
`endif

  for (genvar i = 0; i < NLEDS; i++) begin : g_lane
    led_bank_lane #(.PWM_BITS(PWM_BITS)) u_lane (
      .clk          (clk),
      .rst          (rst),
      .wr           (wr_en && (wr_addr == 4'(i))),
      .wr_data      (wr_data),
      .pwm_cnt      (pwm_cnt),
      .blink_phase  (blink_phase),
      .breathe_duty (breathe_duty),
      .cfg          (cfg[i]),
      .led          (led[i])
    );
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NLEDS; i++)
      if (wr_addr == 4'(i)) rd_data = cfg[i];
  end
endmodule
